// File: rtl/module_branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The pipeline drives lookups and EX results; the predictor returns redirect info.
interface module_branch_predictor_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc_f;
    logic             ex_valid;
    logic             ex_is_branch;
    logic [WIDTH-1:0] ex_pc;
    logic             ex_taken;
    logic [WIDTH-1:0] ex_target;
    logic             ex_pred_taken;
    logic [WIDTH-1:0] ex_pred_target;
    logic [WIDTH-1:0] pred_target;
    logic [1:0]       pc_sel;
    logic             mispredict;
    logic [WIDTH-1:0] recovery_pc;

    modport master (
        output pc_f, ex_valid, ex_is_branch, ex_pc, ex_taken,
        output ex_target, ex_pred_taken, ex_pred_target,
        input  pred_target, pc_sel, mispredict, recovery_pc
    );

    modport slave (
        input  pc_f, ex_valid, ex_is_branch, ex_pc, ex_taken,
        input  ex_target, ex_pred_taken, ex_pred_target,
        output pred_target, pc_sel, mispredict, recovery_pc
    );
endinterface

// File: rtl/module_branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Zero-latency fetch lookup; EX resolution updates on the next edge.
module module_branch_predictor #(
    parameter int WIDTH   = 32,
    parameter int ENTRIES = 16
) (
    input logic clk,
    input logic rst_n,
    module_branch_predictor_if.slave bp
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TW  = WIDTH - IDX - 2;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    logic             valid_q [ENTRIES];
    logic             valid_d [ENTRIES];
    logic [TW-1:0]    tag_q   [ENTRIES];
    logic [TW-1:0]    tag_d   [ENTRIES];
    logic [WIDTH-1:0] tgt_q   [ENTRIES];
    logic [WIDTH-1:0] tgt_d   [ENTRIES];
    cnt_e             cnt_q   [ENTRIES];
    cnt_e             cnt_d   [ENTRIES];

    logic [IDX-1:0] f_idx, e_idx;
    logic [TW-1:0]  f_tag, e_tag;
    logic           hit_f, hit_e, pred_taken_f;
    logic           resolve, wrong;
    cnt_e           cnt_nx;
    logic           unused_pc_lsbs;

    assign f_idx = bp.pc_f[IDX+1:2];
    assign f_tag = bp.pc_f[WIDTH-1:IDX+2];
    assign e_idx = bp.ex_pc[IDX+1:2];
    assign e_tag = bp.ex_pc[WIDTH-1:IDX+2];

    // Word-aligned PCs never use the byte offset bits.
    assign unused_pc_lsbs = ^{bp.pc_f[1:0], bp.ex_pc[1:0]};

    // Fetch lookup and resolve-side hit detection against current contents.
    always_comb begin
        hit_f        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        hit_e        = valid_q[e_idx] && (tag_q[e_idx] == e_tag);
        pred_taken_f = hit_f && (cnt_q[f_idx] == WT || cnt_q[f_idx] == ST);
        bp.pred_target = hit_f ? tgt_q[f_idx] : '0;
    end

    // Misprediction detection and next-PC select; silenced while in reset.
    always_comb begin
        resolve = bp.ex_valid && bp.ex_is_branch;
        wrong   = (bp.ex_taken != bp.ex_pred_taken) ||
                  (bp.ex_taken && (bp.ex_target != bp.ex_pred_target));
        bp.mispredict  = rst_n && resolve && wrong;
        bp.pc_sel      = 2'b00;
        bp.recovery_pc = '0;
        if (bp.mispredict) begin
            bp.pc_sel      = bp.ex_taken ? 2'b10 : 2'b11;
            bp.recovery_pc = bp.ex_taken ? bp.ex_target
                           : bp.ex_pc + {{(WIDTH-3){1'b0}}, 3'd4};
        end else if (rst_n && pred_taken_f) begin
            bp.pc_sel = 2'b01;
        end
    end

    // Counter next-state for the resolving entry: saturating up/down.
    always_comb begin
        cnt_nx = cnt_q[e_idx];
        unique case (cnt_q[e_idx])
            SNT: cnt_nx = bp.ex_taken ? WNT : SNT;
            WNT: cnt_nx = bp.ex_taken ? WT  : SNT;
            WT:  cnt_nx = bp.ex_taken ? ST  : WNT;
            ST:  cnt_nx = bp.ex_taken ? ST  : WT;
            default: cnt_nx = WNT;
        endcase
    end

    // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (resolve) begin
            if (hit_e) begin
                cnt_d[e_idx] = cnt_nx;
                if (bp.ex_taken) tgt_d[e_idx] = bp.ex_target;
            end else if (bp.ex_taken) begin
                valid_d[e_idx] = 1'b1;
                tag_d[e_idx]   = e_tag;
                tgt_d[e_idx]   = bp.ex_target;
                cnt_d[e_idx]   = WT;
            end
        end
    end

    // Table state; reset clears everything and drops any in-flight update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                cnt_q[i]   <= WNT;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_module_branch_predictor.sv
// Randomized and directed bench for module_branch_predictor.
// A behavioural BTB model predicts every output combinationally.
module tb_module_branch_predictor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    module_branch_predictor_if #(.WIDTH(32)) bpi ();

    module_branch_predictor #(.WIDTH(32), .ENTRIES(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bp    (bpi)
    );

    // Reference model: entry keyed by PC word index mod 16, owner by PC>>6.
    bit          m_val [16];
    logic [31:0] m_own [16];
    logic [31:0] m_tgt [16];
    int          m_cnt [16];

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int slot(logic [31:0] pc);
        return int'((pc >> 2) % 16);
    endfunction

    function automatic bit m_hit(logic [31:0] pc);
        return m_val[slot(pc)] && (m_own[slot(pc)] == (pc >> 6));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_val[i] = 0;
            m_own[i] = '0;
            m_tgt[i] = '0;
            m_cnt[i] = 1;
        end
    endtask

    task automatic check_outputs(string tag);
        logic [31:0] e_tgt, e_rec;
        logic [1:0]  e_sel;
        bit          e_mis, pt, res;
        res   = bpi.ex_valid && bpi.ex_is_branch;
        e_tgt = m_hit(bpi.pc_f) ? m_tgt[slot(bpi.pc_f)] : 32'h0;
        pt    = m_hit(bpi.pc_f) && (m_cnt[slot(bpi.pc_f)] >= 2);
        e_mis = rst_n && res && ((bpi.ex_taken != bpi.ex_pred_taken) ||
                (bpi.ex_taken && bpi.ex_target != bpi.ex_pred_target));
        e_rec = !e_mis ? 32'h0 : bpi.ex_taken ? bpi.ex_target : bpi.ex_pc + 32'd4;
        e_sel = (e_mis && bpi.ex_taken) ? 2'd2 : e_mis ? 2'd3 :
                (rst_n && pt) ? 2'd1 : 2'd0;
        check({tag, ".pred_target"}, 64'(bpi.pred_target), 64'(e_tgt));
        check({tag, ".pc_sel"}, 64'(bpi.pc_sel), 64'(e_sel));
        check({tag, ".mispredict"}, 64'(bpi.mispredict), 64'(e_mis));
        check({tag, ".recovery_pc"}, 64'(bpi.recovery_pc), 64'(e_rec));
    endtask

    task automatic m_update();
        int s;
        if (!(bpi.ex_valid && bpi.ex_is_branch)) return;
        s = slot(bpi.ex_pc);
        if (m_hit(bpi.ex_pc)) begin
            m_cnt[s] = bpi.ex_taken ? ((m_cnt[s] == 3) ? 3 : m_cnt[s] + 1)
                                    : ((m_cnt[s] == 0) ? 0 : m_cnt[s] - 1);
            if (bpi.ex_taken) m_tgt[s] = bpi.ex_target;
        end else if (bpi.ex_taken) begin
            m_val[s] = 1;
            m_own[s] = bpi.ex_pc >> 6;
            m_tgt[s] = bpi.ex_target;
            m_cnt[s] = 2;
        end
    endtask

    task automatic drive(logic [31:0] pcf, bit v, bit br, logic [31:0] epc,
                         bit tk, logic [31:0] tgt, bit ptk, logic [31:0] ptgt);
        bpi.pc_f           = pcf;
        bpi.ex_valid       = v;
        bpi.ex_is_branch   = br;
        bpi.ex_pc          = epc;
        bpi.ex_taken       = tk;
        bpi.ex_target      = tgt;
        bpi.ex_pred_taken  = ptk;
        bpi.ex_pred_target = ptgt;
    endtask

    // Checks outputs mid-cycle, then lets the edge commit and mirrors it.
    task automatic step(string tag);
        #2;
        check_outputs(tag);
        @(posedge clk);
        if (rst_n) m_update();
        #1;
    endtask

    task automatic resolve(logic [31:0] pcf, logic [31:0] epc, bit tk,
                           logic [31:0] tgt, bit ptk, string tag);
        drive(pcf, 1, 1, epc, tk, tgt, ptk, tgt);
        step(tag);
    endtask

    task automatic lookup(logic [31:0] pcf, string tag);
        drive(pcf, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        step(tag);
    endtask

    initial begin
        logic [31:0] pcs [6];
        m_clear();
        drive(32'h100, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
        #3;
        check_outputs("in_reset");
        check("in_reset.pc_sel_lit", 64'(bpi.pc_sel), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);

        lookup(32'h100, "cold_miss");
        check("cold_miss.pc_sel_lit", 64'(bpi.pc_sel), 64'd0);

        drive(32'h0, 1, 1, 32'h100, 1, 32'h200, 0, 32'h0);
        #2;
        check("alloc.mispredict_lit", 64'(bpi.mispredict), 64'd1);
        check("alloc.pc_sel_lit", 64'(bpi.pc_sel), 64'd2);
        check("alloc.recovery_lit", 64'(bpi.recovery_pc), 64'h200);
        step("alloc");
        lookup(32'h100, "alloc_hit");
        drive(32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        check("alloc_hit.pc_sel_lit", 64'(bpi.pc_sel), 64'd1);
        check("alloc_hit.target_lit", 64'(bpi.pred_target), 64'h200);
        step("alloc_hit2");

        for (int i = 0; i < 4; i++) resolve(32'h100, 32'h100, 0, 32'h0, 1, "sat_dn");
        lookup(32'h100, "sat_floor");
        resolve(32'h100, 32'h100, 1, 32'h200, 0, "sat_up");
        drive(32'h100, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        check("sat_wnt.pc_sel_lit", 64'(bpi.pc_sel), 64'd0);
        step("sat_wnt");

        drive(32'h0, 1, 1, 32'h100, 0, 32'h0, 1, 32'h200);
        #2;
        check("nt_mis.pc_sel_lit", 64'(bpi.pc_sel), 64'd3);
        check("nt_mis.recovery_lit", 64'(bpi.recovery_pc), 64'h104);
        step("nt_mis");

        resolve(32'h0, 32'h100, 1, 32'h300, 0, "alias_prep");
        resolve(32'h0, 32'h140, 1, 32'h400, 0, "alias_evict");
        lookup(32'h100, "alias_old");
        check("alias_old.pc_sel_lit", 64'(bpi.pc_sel), 64'd0);
        lookup(32'h140, "alias_new");

        resolve(32'h0, 32'hFFFF_FFFC, 0, 32'h0, 1, "wrap_pc4");
        drive(32'h140, 1, 1, 32'h180, 1, 32'h500, 0, 32'h0);
        #2;
        check_outputs("pre_areset");
        rst_n = 1'b0;
        m_clear();
        #1;
        check_outputs("areset");
        check("areset.pc_sel_lit", 64'(bpi.pc_sel), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        lookup(32'h140, "post_rst_140");
        lookup(32'h180, "post_rst_180");

        pcs[0] = 32'h100; pcs[1] = 32'h140; pcs[2] = 32'h180;
        pcs[3] = 32'h104; pcs[4] = 32'h1C4; pcs[5] = 32'hFFFF_FFFC;
        for (int n = 0; n < 600; n++) begin
            logic [31:0] epc, tgt, ptgt;
            bit tk, ptk;
            epc  = pcs[$urandom_range(0, 5)];
            tk   = 1'($urandom);
            tgt  = {22'h0, 8'($urandom_range(0, 3) * 64), 2'b00};
            ptk  = 1'($urandom);
            ptgt = ($urandom_range(0, 3) != 0) ? tgt : $urandom;
            drive(pcs[$urandom_range(0, 5)], ($urandom_range(0, 4) != 0),
                  1'($urandom), epc, tk, tgt, ptk, ptgt);
            if (n % 97 == 50) begin
                #2;
                rst_n = 1'b0;
                m_clear();
                #1;
                check_outputs("rand_rst");
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                @(negedge clk);
            end else begin
                step("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/module_branch_predictor.md
MODULE_BRANCH_PREDICTOR -- requirements
Module: module_branch_predictor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the PC and target width in bits.
REQ-002 SHALL have parameter ENTRIES, default 16, giving the BTB depth; it is a power of two and at least 2; IDX = log2(ENTRIES).
REQ-003 SHALL have port clk  input  1  single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port pc_f  input  WIDTH  fetch-stage PC being looked up.
REQ-006 SHALL have port ex_valid  input  1  EX stage holds a valid instruction.
REQ-007 SHALL have port ex_is_branch  input  1  EX instruction is a conditional branch or jump.
REQ-008 SHALL have port ex_pc  input  WIDTH  PC of the EX instruction.
REQ-009 SHALL have port ex_taken  input  1  resolved direction.
REQ-010 SHALL have port ex_target  input  WIDTH  resolved target.
REQ-011 SHALL have port ex_pred_taken  input  1  prediction made for this instruction, carried down the pipeline.
REQ-012 SHALL have port ex_pred_target  input  WIDTH  predicted target carried down the pipeline.
REQ-013 SHALL have port pred_target  output  WIDTH  BTB target for pc_f; 0 on miss.
REQ-014 SHALL have port pc_sel  output  2  select for the next-PC 4:1 mux: 00 = pc_f+4, 01 = pred_target, 10 = ex_target, 11 = ex_pc+4.
REQ-015 SHALL have port mispredict  output  1  flush request to the IF/ID and ID/EX registers.
REQ-016 SHALL have port recovery_pc  output  WIDTH  correct next PC when mispredict is 1, else 0.

Function
REQ-017 SHALL hold ENTRIES entries, each with valid (1 bit), tag (WIDTH-IDX-2 bits), target (WIDTH bits) and a 2-bit counter.
REQ-018 SHALL index the table with pc[IDX+1:2] and tag it with pc[WIDTH-1:IDX+2].
REQ-019 SHALL look up pc_f combinationally (zero latency); hit = valid and tag match.
REQ-020 SHALL define the predicted direction as hit and counter[1] = 1.
REQ-021 SHALL run each counter as an FSM with states SNT=00, WNT=01, WT=10, ST=11: taken increments and saturates at ST; not-taken decrements and saturates at SNT.
REQ-022 SHALL define a resolve event as ex_valid and ex_is_branch both 1; no state changes in any cycle without a resolve event.
REQ-023 SHALL assert mispredict = resolve and (ex_taken != ex_pred_taken, or ex_taken and ex_target != ex_pred_target), combinationally.
REQ-024 SHALL drive pc_sel with this priority: mispredict and ex_taken -> 10; mispredict and not ex_taken -> 11; predicted taken -> 01; otherwise 00.
REQ-025 SHALL drive recovery_pc = ex_target if ex_taken, else ex_pc+4, with ex_pc+4 computed modulo 2^WIDTH.
REQ-026 SHALL, on a resolve event that hits ex_pc's entry, update the counter per REQ-021 on the next edge and write ex_target into target when ex_taken.
REQ-027 SHALL, on a resolve event that misses with ex_taken = 1, allocate the entry (overwriting any occupant) with valid = 1, tag, target = ex_target and counter = WT.
REQ-028 SHALL NOT allocate an entry on a miss with ex_taken = 0.
REQ-029 SHALL return pre-update contents when pc_f and ex_pc map to the same index in one cycle; the update is visible from the next cycle.

Reset
REQ-030 SHALL, while rst_n = 0, clear all valid bits, set all counters to WNT and all tags and targets to 0, independent of clk.
REQ-031 SHALL, during reset, output pc_sel = 00, mispredict = 0 and recovery_pc = 0 regardless of inputs.
REQ-032 SHALL treat a reset asserted mid-update as discarding that update, with the table fully cleared on release.

Verification
REQ-033 SHALL verify cold miss: after reset, pc_f = 0x100 -> pc_sel = 00, pred_target = 0.
REQ-034 SHALL verify allocation: resolve ex_pc = 0x100, taken, target 0x200, pred_taken 0 -> mispredict = 1, pc_sel = 10, recovery_pc = 0x200; next cycle pc_f = 0x100 -> pc_sel = 01, pred_target = 0x200.
REQ-035 SHALL verify saturation: four not-taken resolves of 0x100 -> counter 10->01->00->00; pc_f = 0x100 -> pc_sel = 00; a single taken resolve -> counter 01, still 00.
REQ-036 SHALL verify not-taken mispredict: ex_pc = 0x100, pred_taken 1, taken 0 -> pc_sel = 11, recovery_pc = 0x104.
REQ-037 SHALL verify aliasing: with ENTRIES = 16, 0x100 is allocated, then 0x140 is resolved taken -> entry replaced; pc_f = 0x100 -> miss, pc_sel = 00.
REQ-038 SHALL verify asynchronous reset: rst_n pulsed low between edges while entries are valid -> outputs drop immediately; all lookups miss afterward.
